// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// fields and ALU operation codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op and the instruction funct field to an ALU control code.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath; one shared ALU and memory are
// steered per state, memory states stall on mem_ready.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             illegal_instr,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t     st, nxt;
  logic [1:0] alu_op;
  logic       funct_illegal;
  logic       ir_w, pc_w, br, mem_w, reg_w, retire;

  alu_decoder u_alu_dec (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_control),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_FETCH;
    else     st <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_count <= '0;
    else if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    nxt           = st;
    alu_op        = ALUOP_ADD;
    i_or_d        = 1'b0;
    ir_w          = 1'b0;
    pc_w          = 1'b0;
    br            = 1'b0;
    mem_w         = 1'b0;
    reg_w         = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    illegal_instr = 1'b0;
    retire        = 1'b0;
    case (st)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_w      = mem_ready;
        pc_w      = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default: begin
            illegal_instr = 1'b1;
            nxt           = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        i_or_d = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_w      = 1'b1;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWRITE: begin
        i_or_d = 1'b1;
        mem_w  = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        if (funct_illegal) begin
          illegal_instr = 1'b1;
          nxt           = S_FETCH;
        end else begin
          nxt = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_w   = 1'b1;
        retire  = 1'b1;
        nxt     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        br        = 1'b1;
        pc_src    = 2'b01;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_w  = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_w   = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes are masked during reset so a held-ready memory cannot load IR/PC.
  assign ir_write  = ir_w & ~rst;
  assign mem_write = mem_w & ~rst;
  assign reg_write = reg_w & ~rst;
  assign pc_en     = (pc_w | (br & zero)) & ~rst;
  assign state     = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench: each issued instruction expands into expected per-cycle
// observations from a reference model; a negedge monitor compares them with the DUT.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          i_or_d, ir_write, mem_write, mem_to_reg, reg_dst, reg_write;
  logic          alu_src_a, pc_en, illegal_instr;
  logic [1:0]    alu_src_b, pc_src;
  logic [2:0]    alu_control;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  typedef struct packed {
    logic [3:0]    st;
    logic          ir, pcen, mw, rw, m2r, rd, iord, a;
    logic [1:0]    b;
    logic [2:0]    alu;
    logic [1:0]    psrc;
    logic          ill;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .i_or_d(i_or_d), .ir_write(ir_write),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_instr(illegal_instr), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic bit op_legal(logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  function automatic bit fn_legal(logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  // Expected observation for one cycle spent in step s of an instruction.
  function automatic obs_t expect_step(int s, logic [5:0] op, logic [5:0] fn,
                                       logic mr, logic z, logic [CW-1:0] cnt);
    obs_t e = '0;
    e.st = s[3:0];
    e.alu = 3'b010;
    e.cnt = cnt;
    case (s)
      0:  begin e.b = 2'b01; e.ir = mr; e.pcen = mr; end
      1:  begin e.b = 2'b11; e.ill = !op_legal(op); end
      2:  begin e.a = 1; e.b = 2'b10; end
      3:  e.iord = 1;
      4:  begin e.m2r = 1; e.rw = 1; end
      5:  begin e.iord = 1; e.mw = 1; end
      6:  begin
            e.a = 1;
            e.ill = !fn_legal(fn);
            if (fn == 6'b100010) e.alu = 3'b110;
            else if (fn == 6'b100100) e.alu = 3'b000;
            else if (fn == 6'b100101) e.alu = 3'b001;
            else if (fn == 6'b101010) e.alu = 3'b111;
          end
      7:  begin e.rd = 1; e.rw = 1; end
      8:  begin e.a = 1; e.alu = 3'b110; e.psrc = 2'b01; e.pcen = z; end
      9:  begin e.a = 1; e.b = 2'b10; end
      10: e.rw = 1;
      11: begin e.psrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(int s, logic [5:0] op, logic [5:0] fn, logic mr, logic z);
    mem_ready = mr;
    zero      = z;
    sb.push_back(expect_step(s, op, fn, mr, z, exp_cnt));
    @(posedge clk); #1;
  endtask

  // zmode: 0/1 forces zero, 2 randomizes it each cycle.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int fst, int mst, int zmode);
    logic zb;
    opcode = op;
    funct  = fn;
    zb = (zmode == 2) ? 1'($urandom) : 1'(zmode);
    for (int i = 0; i < fst; i++) step(0, op, fn, 1'b0, zb);
    step(0, op, fn, 1'b1, zb);
    step(1, op, fn, 1'($urandom), zb);
    case (op)
      6'b100011: begin
        step(2, op, fn, 1'($urandom), zb);
        for (int i = 0; i < mst; i++) step(3, op, fn, 1'b0, zb);
        step(3, op, fn, 1'b1, zb);
        step(4, op, fn, 1'($urandom), zb);
        exp_cnt++;
      end
      6'b101011: begin
        step(2, op, fn, 1'($urandom), zb);
        for (int i = 0; i < mst; i++) step(5, op, fn, 1'b0, zb);
        step(5, op, fn, 1'b1, zb);
        exp_cnt++;
      end
      6'b000000: begin
        step(6, op, fn, 1'($urandom), zb);
        if (fn_legal(fn)) begin
          step(7, op, fn, 1'($urandom), zb);
          exp_cnt++;
        end
      end
      6'b000100: begin step(8, op, fn, 1'($urandom), zb); exp_cnt++; end
      6'b001000: begin
        step(9, op, fn, 1'($urandom), zb);
        step(10, op, fn, 1'($urandom), zb);
        exp_cnt++;
      end
      6'b000010: begin step(11, op, fn, 1'($urandom), zb); exp_cnt++; end
      default: ;
    endcase
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_count"}, 32'(instr_count), 32'd0);
    check({tag, "_wen"}, {28'd0, ir_write, pc_en, mem_write, reg_write}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t e, a;
      e = sb.pop_front();
      a = '{st: state, ir: ir_write, pcen: pc_en, mw: mem_write, rw: reg_write,
            m2r: mem_to_reg, rd: reg_dst, iord: i_or_d, a: alu_src_a, b: alu_src_b,
            alu: alu_control, psrc: pc_src, ill: illegal_instr, cnt: instr_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs st=%0d: got %h expected %h", e.st, a, e);
      end
    end
  end

  localparam logic [5:0] OPS[6] = '{6'b100011, 6'b101011, 6'b000000,
                                    6'b000100, 6'b001000, 6'b000010};
  localparam logic [5:0] FNS[5] = '{6'b100000, 6'b100010, 6'b100100,
                                    6'b100101, 6'b101010};

  initial begin
    logic [5:0] op, fn;
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    exp_cnt = '0;
    @(posedge clk); #1;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    run_instr(6'b100011, 6'b0, 0, 0, 2);
    run_instr(6'b101011, 6'b0, 3, 2, 2);
    run_instr(6'b000000, 6'b100010, 0, 0, 2);
    run_instr(6'b000000, 6'b101010, 0, 0, 2);
    run_instr(6'b000000, 6'b000111, 0, 0, 2);
    run_instr(6'b000100, 6'b0, 0, 0, 1);
    run_instr(6'b000100, 6'b0, 0, 0, 0);
    run_instr(6'b111111, 6'b0, 0, 0, 2);
    run_instr(6'b001000, 6'b0, 1, 0, 2);
    run_instr(6'b000010, 6'b0, 0, 0, 2);

    // Randomized mix; more than 16 retires so the 4-bit counter wraps.
    for (int n = 0; n < 120; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 4)];
      run_instr(op, fn, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 2);
    end

    // Abandon a lw in MEMREAD with an asynchronous reset.
    if (exp_cnt == '0) run_instr(6'b000010, 6'b0, 0, 0, 2);
    opcode = 6'b100011;
    step(0, opcode, 6'b0, 1'b1, 1'b0);
    step(1, opcode, 6'b0, 1'b1, 1'b0);
    step(2, opcode, 6'b0, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1 check("pre_reset_state", 32'(state), 32'd3);
    check("pre_reset_count", 32'(instr_count), 32'(exp_cnt));
    mem_ready = 1'b1;
    #1 rst = 1'b1;
    #1 check_reset_outputs("async");
    @(posedge clk); #1;
    check_reset_outputs("held");
    rst = 1'b0;
    exp_cnt = '0;
    run_instr(6'b001000, 6'b0, 0, 0, 2);
    run_instr(6'b100011, 6'b0, 0, 1, 2);

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS datapath. Each instruction is sequenced through a Moore state machine that drives the shared ALU's operand selects and `alu_control`, plus the register-file, memory, IR and PC enables, so one ALU and one memory serve fetch, address and execute steps. Memory steps stall on a `mem_ready` handshake. A retired-instruction counter is kept for debug.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `i_or_d` out 1: 0 = PC addresses memory, 1 = ALUOut addresses memory.
- `ir_write` out 1: load IR.
- `mem_write` out 1: memory write strobe.
- `mem_to_reg` out 1: 1 = writeback from data register.
- `reg_dst` out 1: 1 = write to rd.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_control` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en` out 1: PC load, equal to `pc_write | (branch & zero)`.
- `illegal_instr` out 1: one-cycle pulse in DECODE for an unsupported opcode, or in EXECUTE for an unsupported funct.
- `state` out 4: current state code, for debug.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 go to FETCH.
- FETCH: `alu_src_a`=0, `alu_src_b`=01, ADD, `pc_src`=00. While `mem_ready`=0: hold, with `ir_write`=`pc_write`=0. When `mem_ready`=1: `ir_write`=`pc_write`=1, then go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, ADD (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode: pulse `illegal_instr`, go to FETCH, no retire.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, ADD. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: `i_or_d`=1. Hold until `mem_ready`, then MEMWB.
- MEMWB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1, then FETCH.
- MEMWRITE: `i_or_d`=1, `mem_write`=1 while waiting. Go to FETCH on `mem_ready`.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_control` from funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. For any other funct: `alu_control`=010, pulse `illegal_instr`, go to FETCH with no retire.
- ALUWB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1, then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, SUB, `branch`=1, `pc_src`=01, then FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, ADD, then ADDIWB.
- ADDIWB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1, then FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, then FETCH.
- Default for any output not listed in a state: 0. Default `alu_control` is 010.
- `instr_count` increments by 1, wrapping modulo 2^CNT_W, on each transition into FETCH from MEMWB, MEMWRITE (with `mem_ready`), ALUWB, BRANCH, ADDIWB or JUMP.

## Timing
- Reset is asynchronous: `state`=FETCH and `instr_count`=0 immediately.
- While `rst`=1, `ir_write`, `pc_en`, `mem_write` and `reg_write` are forced to 0 combinationally. All other outputs show their FETCH values.
- Outputs are a combinational decode of the registered state only, with two exceptions: the `mem_ready` gating in FETCH and the `zero` term in `pc_en`.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset asserted mid-instruction abandons that instruction with no retire. The first FETCH comes on the first edge after `rst` falls.

## Structure
- Package `mips_pkg` holds:
  - the `state_t` enum with the codes above;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`;
  - funct constants;
  - ALU op constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`.
- One sub-module, `alu_decoder`: combinational mapping of (`alu_op[1:0]`, `funct`) to (`alu_control`, `funct_illegal`). `alu_op` is 00 for ADD, 01 for SUB, 10 for funct-decoded.

## Test plan
- Reset mid-MEMREAD: assert `rst`. Expect `state`=0 in the same cycle, `instr_count`=0, all write enables 0. After release, FETCH proceeds.
- lw (opcode 100011) with `mem_ready`=1: states 0,1,2,3,4,0 across 5 cycles; `reg_write`=1 and `mem_to_reg`=1 only in state 4; `instr_count` increments by 1.
- `mem_ready` held 0 for 3 cycles in FETCH, then sw: FETCH lasts 4 cycles with no `ir_write` until the 4th; `mem_write`=1 throughout MEMWRITE.
- R-type with funct 100010, then 101010: `alu_control` is 110, then 111, in EXECUTE. Funct 000111 → `illegal_instr` pulse and return to FETCH with count unchanged.
- beq with `zero`=1: `pc_en`=1 and `pc_src`=01 in BRANCH. With `zero`=0: `pc_en`=0. Both take 3 cycles.
- Opcode 111111: `illegal_instr` pulses in DECODE, next state is FETCH, `instr_count` unchanged. `CNT_W`=4 with 16 retires: count wraps to 0.
